ram_readback_checker: RTL and testbench
=======================================

RAM_READBACK_CHECKER -- requirements
Module: ram_readback_checker

Interface
REQ-001 The block SHALL have parameter A_WIDTH, default 6, meaning the address width; it checks 2^A_WIDTH locations.
REQ-002 The block SHALL have parameter READ_LAT, default 1, legal range 1..15, meaning the cycles each address is held before q_i is sampled.
REQ-003 The block SHALL have parameter PATTERN, default 1, meaning the expected data: 0 = all zeros, 1 = addr[0], 2 = ~addr[0].
REQ-004 The block SHALL have parameter ERR_W, default 7, meaning the width of the error counter.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 start_i  input  1  begin a check pass; level-sampled.
REQ-008 q_i  input  1  read data from the RAM under test.
REQ-009 addr_o  output  A_WIDTH  registered read address to the RAM.
REQ-010 busy_o  output  1  high while a pass is in progress.
REQ-011 done_o  output  1  high after a pass completes; held until the next start or reset.
REQ-012 pass_o  output  1  equals done_o AND (err_count_o == 0).
REQ-013 err_count_o  output  ERR_W  count of mismatches, saturating.
REQ-014 first_err_valid_o  output  1  high once a mismatch has been captured in the current pass.
REQ-015 first_err_addr_o  output  A_WIDTH  address of the first mismatch in the current pass.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In IDLE or DONE, start_i=1 at an edge SHALL, on that edge: enter RUN, set addr_o=0, clear err_count_o and first_err_valid_o, clear done_o, and set the hold counter to 0.
REQ-018 In RUN, start_i SHALL be ignored.
REQ-019 In RUN, addr_o SHALL be held for exactly READ_LAT cycles, and q_i SHALL be sampled on the last edge of that window.
REQ-020 On the sampling edge, a mismatch SHALL be q_i != expected(addr_o), with expected() defined by PATTERN.
REQ-021 On a mismatch, err_count_o SHALL increment and saturate at 2^ERR_W-1.
REQ-022 On a mismatch, if first_err_valid_o=0, the block SHALL capture first_err_addr_o=addr_o and set first_err_valid_o=1; later mismatches SHALL NOT change the capture.
REQ-023 On the sampling edge, if addr_o is below its maximum value, addr_o SHALL increment by 1.
REQ-024 On the sampling edge at addr_o = 2^A_WIDTH-1, the block SHALL enter DONE, set done_o=1, and leave addr_o at its maximum (no wrap); the error update for this final sample SHALL occur on the same edge.
REQ-025 busy_o SHALL be 1 exactly in RUN; a pass SHALL last 2^A_WIDTH*READ_LAT cycles from the first RUN cycle to the first DONE cycle.
REQ-026 In DONE, all result outputs SHALL hold until start_i or rst_i.
REQ-027 A start_i held high continuously SHALL restart a pass on the first edge after entering DONE.
REQ-028 A PATTERN value outside 0..2 SHALL behave as 0.

Reset
REQ-029 rst_i=1 at an edge SHALL force IDLE and set addr_o=0, busy_o=0, done_o=0, err_count_o=0, first_err_valid_o=0, first_err_addr_o=0, and the hold counter to 0.
REQ-030 rst_i SHALL take priority over start_i.
REQ-031 rst_i asserted mid-pass SHALL abort the pass with no partial results retained.
REQ-032 After reset, pass_o SHALL be 0.

Verification
REQ-033 Defaults, with an ideal RAM model returning addr[0]: pulse start -> busy_o high for 64 cycles, addr_o steps 0..63, then done_o=1, pass_o=1, err_count_o=0, first_err_valid_o=0.
REQ-034 Defaults, with model bits flipped at addresses 5 and 40 -> err_count_o=2, first_err_addr_o=5, first_err_valid_o=1, pass_o=0.
REQ-035 Defaults, with q_i stuck at 0 -> err_count_o=32, first_err_addr_o=1; then rerun with PATTERN=0 -> pass_o=1.
REQ-036 READ_LAT=3 -> each address is held for 3 cycles and sampled on the 3rd, with busy_o high for 192 cycles; a glitch injected in cycle 1 or 2 of an address window -> no error counted.
REQ-037 ERR_W=4, with q_i inverted for all addresses -> err_count_o saturates at 15 and first_err_addr_o=0.
REQ-038 Assert rst_i at addr_o=20 -> next cycle IDLE with all outputs 0; a start pulse during RUN is ignored (addr sequence unbroken); a fresh start then completes a full 64-address pass.

Source files
------------

// File: rtl/ram_readback_checker.sv
// RAM readback checker: walks every address of a RAM, holds each address for
// READ_LAT cycles, compares the returned bit against a fixed data pattern and
// records the mismatch count plus the address of the first mismatch.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | after reset, waiting for start_i
// ST_RUN  | pass in progress, addr_o held READ_LAT cycles per location
// ST_DONE | pass complete, results frozen until start_i or rst_i
module ram_readback_checker #(
    parameter int A_WIDTH  = 6,
    parameter int READ_LAT = 1,
    parameter int PATTERN  = 1,
    parameter int ERR_W    = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               q_i,
    output logic [A_WIDTH-1:0] addr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic               first_err_valid_o,
    output logic [A_WIDTH-1:0] first_err_addr_o
);

    localparam int                 HOLD_W    = 4;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(READ_LAT - 1);
    localparam logic [A_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [ERR_W-1:0]   ERR_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start_pass;
    logic              sample;
    logic              last_addr;
    logic              expected;
    logic              mismatch;
    logic [HOLD_W-1:0] hold_cnt;

    // Sampling strobe, pattern lookup and mismatch detection for the current address.
    always_comb begin
        sample    = (state == ST_RUN) && (hold_cnt == HOLD_LAST);
        last_addr = (addr_o == ADDR_MAX);
        case (PATTERN)
            1:       expected = addr_o[0];
            2:       expected = ~addr_o[0];
            default: expected = 1'b0;
        endcase
        mismatch  = sample && (q_i != expected);
    end

    // Next-state decode; start_pass flags the edge that launches a new pass.
    always_comb begin
        state_nxt  = state;
        start_pass = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nxt  = ST_RUN;
                    start_pass = 1'b1;
                end
            end
            ST_RUN: begin
                if (sample && last_addr) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address walk, hold timer and result capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_o            <= '0;
            hold_cnt          <= '0;
            err_count_o       <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
        end else if (start_pass) begin
            addr_o            <= '0;
            hold_cnt          <= '0;
            err_count_o       <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
        end else if (state == ST_RUN) begin
            if (sample) begin
                hold_cnt <= '0;
                // Address parks at its maximum on the final sample.
                if (!last_addr) begin
                    addr_o <= addr_o + 1'b1;
                end
                if (mismatch) begin
                    if (err_count_o != ERR_MAX) begin
                        err_count_o <= err_count_o + 1'b1;
                    end
                    if (!first_err_valid_o) begin
                        first_err_valid_o <= 1'b1;
                        first_err_addr_o  <= addr_o;
                    end
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign busy_o = (state == ST_RUN);
    assign done_o = (state == ST_DONE);
    assign pass_o = done_o && (err_count_o == '0);

endmodule

// File: tb/tb_ram_readback_checker.sv
// Bench for ram_readback_checker: five instances with different parameter sets
// share clock/start/reset; each sees its own RAM model. Expected pass results
// are queued at each start and checked by a monitor when done_o rises.
module tb_ram_readback_checker;

    localparam int N = 5;

    typedef struct {
        int id;
        int err;
        bit fv;
        int fa;
        bit ps;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;         // 0 ideal, 1 flips at 5 and 40, 2 stuck at 0
    logic glitch_en = 1'b1;
    logic glitch1 = 1'b0;

    logic       q_a       [N];
    logic [5:0] addr_a    [N];
    logic       busy_a    [N];
    logic       done_a    [N];
    logic       pass_a    [N];
    logic [6:0] errc_a    [N];
    logic       fv_a      [N];
    logic [5:0] fa_a      [N];
    logic [3:0] err2;

    int   tests = 0;
    int   fails = 0;
    int   rc    [N] = '{0, 0, 0, 0, 0};
    int   lat   [N] = '{1, 3, 1, 1, 1};
    logic prev_done [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic ram_model(input logic [5:0] a);
        if (mode == 2) return 1'b0;
        if (mode == 1 && (a == 6'd5 || a == 6'd40)) return ~a[0];
        return a[0];
    endfunction

    always_comb begin
        q_a[0] = ram_model(addr_a[0]);
        q_a[1] = addr_a[1][0] ^ glitch1;
        q_a[2] = ~addr_a[2][0];
        q_a[3] = ram_model(addr_a[3]);
        q_a[4] = ram_model(addr_a[4]);
    end

    ram_readback_checker u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .q_i(q_a[0]), .addr_o(addr_a[0]),
        .busy_o(busy_a[0]), .done_o(done_a[0]), .pass_o(pass_a[0]), .err_count_o(errc_a[0]),
        .first_err_valid_o(fv_a[0]), .first_err_addr_o(fa_a[0]));

    ram_readback_checker #(.READ_LAT(3)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .q_i(q_a[1]), .addr_o(addr_a[1]),
        .busy_o(busy_a[1]), .done_o(done_a[1]), .pass_o(pass_a[1]), .err_count_o(errc_a[1]),
        .first_err_valid_o(fv_a[1]), .first_err_addr_o(fa_a[1]));

    ram_readback_checker #(.ERR_W(4)) u2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .q_i(q_a[2]), .addr_o(addr_a[2]),
        .busy_o(busy_a[2]), .done_o(done_a[2]), .pass_o(pass_a[2]), .err_count_o(err2),
        .first_err_valid_o(fv_a[2]), .first_err_addr_o(fa_a[2]));
    assign errc_a[2] = {3'b000, err2};

    ram_readback_checker #(.PATTERN(0)) u3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .q_i(q_a[3]), .addr_o(addr_a[3]),
        .busy_o(busy_a[3]), .done_o(done_a[3]), .pass_o(pass_a[3]), .err_count_o(errc_a[3]),
        .first_err_valid_o(fv_a[3]), .first_err_addr_o(fa_a[3]));

    ram_readback_checker #(.PATTERN(2)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .q_i(q_a[4]), .addr_o(addr_a[4]),
        .busy_o(busy_a[4]), .done_o(done_a[4]), .pass_o(pass_a[4]), .err_count_o(errc_a[4]),
        .first_err_valid_o(fv_a[4]), .first_err_addr_o(fa_a[4]));

    task automatic chk(input string name, input int id, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, id, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int err, input bit fv, input int fa,
                        input bit ps, input int cyc);
        exp_t e;
        e.id = id; e.err = err; e.fv = fv; e.fa = fa; e.ps = ps; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic check_done(input int i);
        int   idx;
        exp_t e;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].id == i) idx = k;
        end
        if (idx < 0) begin
            chk("unexpected_done", i, done_a[i], 0);
            return;
        end
        e = sb[idx];
        sb.delete(idx);
        chk("err_count", i, errc_a[i], e.err);
        chk("first_err_valid", i, fv_a[i], e.fv);
        if (e.fv) chk("first_err_addr", i, fa_a[i], e.fa);
        chk("pass", i, pass_a[i], e.ps);
        chk("busy_cycles", i, rc[i], e.cyc);
    endtask

    // Monitor: address sequencing while busy, scoreboard pop when done rises.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (busy_a[i]) begin
                    if (i == 1) glitch1 = glitch_en && ((rc[i] % 3) != 2);
                    chk("addr_seq", i, addr_a[i], rc[i] / lat[i]);
                    rc[i]++;
                end else begin
                    if (i == 1) glitch1 = 1'b0;
                    if (done_a[i] && !prev_done[i]) check_done(i);
                    rc[i] = 0;
                end
                prev_done[i] = done_a[i];
            end
        end
    end

    task automatic check_cleared();
        for (int i = 0; i < N; i++) begin
            chk("rst_addr", i, addr_a[i], 0);
            chk("rst_busy", i, busy_a[i], 0);
            chk("rst_done", i, done_a[i], 0);
            chk("rst_pass", i, pass_a[i], 0);
            chk("rst_err", i, errc_a[i], 0);
            chk("rst_fv", i, fv_a[i], 0);
            chk("rst_fa", i, fa_a[i], 0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_all_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = done_a[0] && done_a[1] && done_a[2] && done_a[3] && done_a[4];
        end
        chk("all_done_timeout", 0, ok, 1);
    endtask

    task automatic wait_addr0(input int a, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = busy_a[0] && (addr_a[0] == 6'(a));
        end
        chk("addr_wait_timeout", 0, ok, 1);
    endtask

    task automatic push_ideal(input bit with_d1);
        push(0, 0, 0, 0, 1, 64);
        if (with_d1) push(1, 0, 0, 0, 1, 192);
        push(2, 15, 1, 0, 0, 64);
        push(3, 32, 1, 1, 0, 64);
        push(4, 64, 1, 0, 0, 64);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_cleared();

        // Ideal RAM.
        mode = 0;
        push_ideal(1'b1);
        pulse_start();
        wait_all_done(400);

        // Flipped bits at 5 and 40.
        mode = 1;
        push(0, 2, 1, 5, 0, 64);
        push(1, 0, 0, 0, 1, 192);
        push(2, 15, 1, 0, 0, 64);
        push(3, 32, 1, 1, 0, 64);
        push(4, 62, 1, 0, 0, 64);
        pulse_start();
        wait_all_done(400);

        // Stuck at 0.
        mode = 2;
        push(0, 32, 1, 1, 0, 64);
        push(1, 0, 0, 0, 1, 192);
        push(2, 15, 1, 0, 0, 64);
        push(3, 0, 0, 0, 1, 64);
        push(4, 32, 1, 0, 0, 64);
        pulse_start();
        wait_all_done(400);

        // Start during RUN is ignored; reset mid-pass aborts everything.
        mode = 0;
        pulse_start();
        wait_addr0(10, 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_addr0(20, 100);
        rst = 1'b1;
        @(negedge clk);
        check_cleared();
        rst = 1'b0;

        // Fresh full pass after the abort.
        push_ideal(1'b1);
        pulse_start();
        wait_all_done(400);

        // start_i held high restarts on the first edge after DONE.
        push_ideal(1'b0);
        @(negedge clk);
        start = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                seen = done_a[0];
            end
            chk("held_done_timeout", 0, seen, 1);
        end
        @(negedge clk);
        chk("held_restart_busy", 0, busy_a[0], 1);
        chk("held_restart_done", 0, done_a[0], 0);
        chk("held_restart_addr", 0, addr_a[0], 0);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_cleared();
        chk("scoreboard_left", 0, sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
